call_ret_ctrl: RTL
==================

Name: call_ret_ctrl

Overview:
- Sequencer between the instruction decoder and the 19-bit hardware return stack. It is the sole master of the stack's push/pop port.
- On CALL it pushes the return address and redirects the PC to the call target.
- On RET it reads the top of stack, pops it, and redirects the PC to that address.
- It detects stack overflow, stack underflow and illegal simultaneous requests, and reports them through a sticky fault.

Parameters:
- ADDR_W, 19, PC/return-address width; must equal the stack data width.
- INSTR_STEP, 1, added to pc_in to form the return address (mod 2^ADDR_W).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- call_req  input  1  CALL request from decode; sampled only when ready=1
- ret_req  input  1  RET request from decode; sampled only when ready=1
- pc_in  input  ADDR_W  PC of the requesting instruction
- call_target  input  ADDR_W  CALL destination
- ready  output  1  high only in IDLE; a request is accepted when req & ready
- pc_load  output  1  one-cycle strobe: load pc_next into the PC
- pc_next  output  ADDR_W  redirect address, valid while pc_load=1
- stk_push  output  1  to stack push
- stk_pop  output  1  to stack pop
- stk_push_data  output  ADDR_W  to stack push_data
- stk_pop_data  input  ADDR_W  from stack pop_data (combinational top-of-stack)
- stk_empty  input  1  from stack
- stk_full  input  1  from stack
- fault  output  1  sticky fault flag
- fault_code  output  2  0 none, 1 overflow, 2 underflow, 3 illegal
- fault_clr  input  1  clears the fault; returns to IDLE
- depth  output  4  current call depth (optional feature)
- max_depth  output  4  high-water mark of depth (optional feature)

Behaviour:
- Reset (async) values:
  - state=IDLE, ready=1.
  - pc_load=0, pc_next=0, stk_push=0, stk_pop=0, stk_push_data=0.
  - fault=0, fault_code=0, depth=0, max_depth=0.
  - Internal registers addr_q=0, tgt_q=0.
- FSM states are IDLE, CALL_PUSH, RET_POP, DONE and FAULT. All outputs are registered or decoded from state plus registers; no input-to-output combinational path exists except stk_pop_data capture.
- IDLE, call_req=1 and ret_req=1 together: go to FAULT with code 3. No stack access occurs.
- IDLE, call_req=1 only:
  - If stk_full=1: go to FAULT with code 1.
  - Otherwise: addr_q <= pc_in + INSTR_STEP (wraps mod 2^ADDR_W), tgt_q <= call_target, go to CALL_PUSH.
- IDLE, ret_req=1 only:
  - If stk_empty=1: go to FAULT with code 2.
  - Otherwise: go to RET_POP.
- CALL_PUSH (1 cycle):
  - stk_push=1 and stk_push_data=addr_q.
  - addr_q <= tgt_q; go to DONE.
- RET_POP (1 cycle):
  - stk_pop=1.
  - addr_q <= stk_pop_data, captured in the same cycle because the stack pointer moves only at the end of this cycle.
  - Go to DONE.
- DONE (1 cycle): pc_load=1 and pc_next=addr_q; go to IDLE.
- Latency: request accepted at edge N gives the stack strobe during cycle N+1 and pc_load during cycle N+2. Throughput is one request per 3 cycles.
- Full/empty are checked only in IDLE. Because this block is the sole stack master, stack state cannot change between the check and the strobe.
- stk_push and stk_pop are never both high, and each is high for exactly one cycle per operation.
- Requests presented while ready=0 are ignored and not queued. Decode must hold the request until it is accepted.
- FAULT:
  - fault=1 with fault_code held; ready=0; no strobes.
  - Stays in FAULT until fault_clr=1, then goes to IDLE with fault=0 and fault_code=0.
  - fault_clr outside FAULT has no effect.
- Reset mid-operation: state returns to IDLE immediately and any in-flight pc_load is dropped. The stack resets on the same signal.
- Stack capacity is 15 entries: stk_full asserts after the 15th push; stk_empty is high after reset.

Optional Feature:
- Macro: CALLRET_DEPTH_EN.
- With the macro defined:
  - depth increments at the CALL_PUSH cycle and decrements at the RET_POP cycle (range 0..15).
  - max_depth <= max(max_depth, depth_next).
  - Neither register is cleared by fault_clr; both are cleared by reset only.
- Without the macro: depth and max_depth are tied to 0 and no counter logic is generated.

Test Plan:
- CALL, pc_in=0x00100, call_target=0x3FF00: expect stk_push at N+1 with stk_push_data=0x00101, then pc_load at N+2 with pc_next=0x3FF00.
- CALL (pc_in=0x7FFFF, target=0x00010) then RET: push data 0x00000 (wrap); the RET expects stk_pop at N+1 and pc_load at N+2 with pc_next=0x00000.
- 15 CALLs with pc_in=k, then a 16th CALL:
  - First 15 succeed.
  - 16th gives fault=1, fault_code=1, no stk_push.
  - fault_clr returns ready=1.
  - With CALLRET_DEPTH_EN, depth=15 and max_depth=15.
- RET after reset: fault_code=2, no stk_pop. Then call_req and ret_req asserted together: fault_code=3, no stack strobes.
- Nested CALLs returning 0x00011, 0x00021, 0x00031, then 3 RETs: pc_next sequence is 0x00031, 0x00021, 0x00011. A request held during busy cycles is accepted only at ready=1.
- Reset asserted during CALL_PUSH: all outputs return to their reset values immediately and no pc_load follows.

Source files
------------

// File: rtl/call_ret_ctrl.sv
// ---------------------------------------------------------------------------
// call_ret_ctrl
//   Sequencer between the instruction decoder and the hardware return stack.
//   It is the only block that drives the stack push/pop port.
//   CALL: pushes pc_in + INSTR_STEP, then redirects the PC to call_target.
//   RET : reads the top of stack while popping it, then redirects the PC there.
//   Overflow, underflow and simultaneous CALL+RET requests park the FSM in a
//   sticky FAULT state until fault_clr is asserted.
//
// Optional feature (macro CALLRET_DEPTH_EN):
//   When defined, depth tracks the live call depth and max_depth holds its
//   high-water mark. Only reset clears them. When undefined, both are tied to 0.
//
// Ports:
//   clk, reset      clock; asynchronous active-high reset
//   call_req        CALL request, taken when ready=1
//   ret_req         RET request, taken when ready=1
//   pc_in           PC of the requesting instruction
//   call_target     CALL destination
//   ready           high only in IDLE
//   pc_load         one-cycle strobe: load pc_next into the PC
//   pc_next         redirect address, valid while pc_load=1
//   stk_push        stack push strobe
//   stk_pop         stack pop strobe
//   stk_push_data   stack push data
//   stk_pop_data    combinational top of stack from the stack
//   stk_empty       stack empty flag
//   stk_full        stack full flag
//   fault           sticky fault flag
//   fault_code      0 none, 1 overflow, 2 underflow, 3 illegal
//   fault_clr       clears the fault and returns to IDLE
//   depth           current call depth (optional feature)
//   max_depth       high-water mark of depth (optional feature)
// ---------------------------------------------------------------------------
module call_ret_ctrl #(
  parameter int ADDR_W     = 19,
  parameter int INSTR_STEP = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call_req,
  input  logic              ret_req,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [ADDR_W-1:0] call_target,
  output logic              ready,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_next,
  output logic              stk_push,
  output logic              stk_pop,
  output logic [ADDR_W-1:0] stk_push_data,
  input  logic [ADDR_W-1:0] stk_pop_data,
  input  logic              stk_empty,
  input  logic              stk_full,
  output logic              fault,
  output logic [1:0]        fault_code,
  input  logic              fault_clr,
  output logic [3:0]        depth,
  output logic [3:0]        max_depth
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALL_PUSH,
    S_RET_POP,
    S_DONE,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE      = 2'd0,
    FC_OVERFLOW  = 2'd1,
    FC_UNDERFLOW = 2'd2,
    FC_ILLEGAL   = 2'd3
  } fault_code_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;   // return address, then redirect address
  logic [ADDR_W-1:0]   tgt_q, tgt_d;     // CALL target parked during the push cycle
  fault_code_e         code_q, code_d;

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d       = state_q;
    addr_d        = addr_q;
    tgt_d         = tgt_q;
    code_d        = code_q;
    ready         = 1'b0;
    pc_load       = 1'b0;
    pc_next       = '0;
    stk_push      = 1'b0;
    stk_pop       = 1'b0;
    stk_push_data = '0;
    fault         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (call_req && ret_req) begin
          code_d  = FC_ILLEGAL;
          state_d = S_FAULT;
        end else if (call_req) begin
          if (stk_full) begin
            code_d  = FC_OVERFLOW;
            state_d = S_FAULT;
          end else begin
            addr_d  = pc_in + ADDR_W'(INSTR_STEP);  // wraps mod 2^ADDR_W
            tgt_d   = call_target;
            state_d = S_CALL_PUSH;
          end
        end else if (ret_req) begin
          if (stk_empty) begin
            code_d  = FC_UNDERFLOW;
            state_d = S_FAULT;
          end else begin
            state_d = S_RET_POP;
          end
        end
      end

      S_CALL_PUSH: begin
        stk_push      = 1'b1;
        stk_push_data = addr_q;
        addr_d        = tgt_q;
        state_d       = S_DONE;
      end

      // The stack pointer only moves at the end of this cycle, so pop_data
      // still shows the entry being popped and can be captured now.
      S_RET_POP: begin
        stk_pop = 1'b1;
        addr_d  = stk_pop_data;
        state_d = S_DONE;
      end

      S_DONE: begin
        pc_load = 1'b1;
        pc_next = addr_q;
        state_d = S_IDLE;
      end

      S_FAULT: begin
        fault = 1'b1;
        if (fault_clr) begin
          code_d  = FC_NONE;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign fault_code = code_q;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      tgt_q   <= '0;
      code_q  <= FC_NONE;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; blocking ones would make results order-dependent.
      state_q <= state_d;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      code_q  <= code_d;
    end
  end

  // --------------------------------------------------------------------------
  // Optional call-depth tracking
  // --------------------------------------------------------------------------
`ifdef CALLRET_DEPTH_EN
  logic [3:0] depth_q, depth_d, max_q;

  always_comb begin
    depth_d = depth_q;
    if (state_q == S_CALL_PUSH)
      depth_d = depth_q + 4'd1;
    else if (state_q == S_RET_POP)
      depth_d = depth_q - 4'd1;
  end

  // Deliberately untouched by fault_clr: the high-water mark must survive a
  // fault so it can be inspected after recovery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_q <= '0;
      max_q   <= '0;
    end else begin
      depth_q <= depth_d;
      max_q   <= (depth_d > max_q) ? depth_d : max_q;
    end
  end

  assign depth     = depth_q;
  assign max_depth = max_q;
`else
  assign depth     = '0;
  assign max_depth = '0;
`endif

endmodule
